door_access_arbiter: RTL and testbench

Shares one password-check/door-open sequence between two entry points (left, right keypads). Arbitrates requests round-robin, checks the granted side's 4-bit code against a fixed password, opens that side's door for a fixed time, and locks the whole unit out with an alarm after repeated wrong codes. Sits in front of the left/right door enables as the single sequencer that drives them.

---
 rtl/door_access_arbiter_if.sv | 28 ++
 rtl/door_access_arbiter.sv | 174 +++++++++++++++++
 tb/tb_door_access_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/door_access_arbiter_if.sv
// Keypad/door signal bundle between the two entry points and the access arbiter.
interface door_access_arbiter_if;
  logic       req_left;
  logic       req_right;
  logic       confirm_left;
  logic       confirm_right;
  logic [3:0] pass_left;
  logic [3:0] pass_right;
  logic       gnt_left;
  logic       gnt_right;
  logic       en_left;
  logic       en_right;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic [2:0] state;

  // Keypad side: drives requests and codes, observes grants and door enables.
  modport master (
    output req_left, req_right, confirm_left, confirm_right, pass_left, pass_right,
    input  gnt_left, gnt_right, en_left, en_right, alarm, fail_cnt, state
  );

  // Arbiter side.
  modport slave (
    input  req_left, req_right, confirm_left, confirm_right, pass_left, pass_right,
    output gnt_left, gnt_right, en_left, en_right, alarm, fail_cnt, state
  );
endinterface

// File: rtl/door_access_arbiter.sv
// Round-robin arbiter sharing one password check / door-open sequence between the left and
// right keypads, with lockout after repeated wrong codes.
module door_access_arbiter #(
  parameter logic [3:0]  PASSWORD    = 4'b1010,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned TIMEOUT     = 12
) (
  input logic                  clk,
  input logic                  rst,
  door_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGrant = 3'd1,
    StCheck = 3'd2,
    StOpen  = 3'd3,
    StFail  = 3'd4,
    StLock  = 3'd5
  } state_e;

  // One shared timer covers the GRANT timeout, OPEN and LOCK durations.
  localparam int unsigned MaxCycles =
      (OPEN_CYCLES > LOCK_CYCLES) ?
      ((OPEN_CYCLES > TIMEOUT) ? OPEN_CYCLES : TIMEOUT) :
      ((LOCK_CYCLES > TIMEOUT) ? LOCK_CYCLES : TIMEOUT);
  localparam int unsigned TimerW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] OpenLast    = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast    = TimerW'(LOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT - 1);
  localparam logic [1:0]        MaxFail     = 2'(MAX_FAIL);

  state_e              state_q, state_d;
  logic                side_q, side_d;  // 0 = left, 1 = right
  logic                last_q, last_d;  // side served most recently
  logic [1:0]          fail_q, fail_d;
  logic [3:0]          code_q, code_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                sel_req, sel_confirm;
  logic [3:0]          sel_pass;
  logic [1:0]          fail_inc;
  logic                serve, open, lock;
  logic [2:0]          state_out;

  // Only the granted side's inputs are ever looked at.
  assign sel_req     = side_q ? bus.req_right     : bus.req_left;
  assign sel_confirm = side_q ? bus.confirm_right : bus.confirm_left;
  assign sel_pass    = side_q ? bus.pass_right    : bus.pass_left;
  assign fail_inc    = fail_q + 2'd1;

  // State and datapath registers; last_q resets to right so left wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      side_q  <= 1'b0;
      last_q  <= 1'b1;
      fail_q  <= 2'd0;
      code_q  <= 4'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      last_q  <= last_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic for arbitration, code check, door timing and lockout.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    last_d  = last_q;
    fail_d  = fail_q;
    code_d  = code_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.req_left && bus.req_right) begin
          side_d  = ~last_q;
          state_d = StGrant;
        end else if (bus.req_left) begin
          side_d  = 1'b0;
          state_d = StGrant;
        end else if (bus.req_right) begin
          side_d  = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Confirm beats a simultaneous request drop or timeout.
        if (sel_confirm) begin
          code_d  = sel_pass;
          state_d = StCheck;
        end else if (!sel_req || (timer_q == TimeoutLast)) begin
          last_d  = side_q;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCheck: begin
        timer_d = '0;
        if (code_q == PASSWORD) begin
          fail_d  = 2'd0;
          state_d = StOpen;
        end else begin
          fail_d  = fail_inc;
          state_d = (fail_inc == MaxFail) ? StLock : StFail;
        end
      end
      StOpen: begin
        if (timer_q == OpenLast) begin
          last_d  = side_q;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFail: begin
        last_d  = side_q;
        state_d = StIdle;
      end
      StLock: begin
        if (timer_q == LockLast) begin
          fail_d  = 2'd0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode; unused encodings look like IDLE.
  always_comb begin
    serve     = 1'b0;
    open      = 1'b0;
    lock      = 1'b0;
    state_out = 3'd0;
    case (state_q)
      StIdle:                  state_out = state_q;
      StGrant, StCheck, StFail: begin
        serve     = 1'b1;
        state_out = state_q;
      end
      StOpen: begin
        serve     = 1'b1;
        open      = 1'b1;
        state_out = state_q;
      end
      StLock: begin
        lock      = 1'b1;
        state_out = state_q;
      end
      default: state_out = 3'd0;
    endcase
  end

  assign bus.gnt_left  = serve & ~side_q;
  assign bus.gnt_right = serve & side_q;
  assign bus.en_left   = open & ~side_q;
  assign bus.en_right  = open & side_q;
  assign bus.alarm     = lock;
  assign bus.fail_cnt  = fail_q;
  assign bus.state     = state_out;

endmodule

// File: tb/tb_door_access_arbiter.sv
// Directed bench: stimulus pushes expected output snapshots into a scoreboard queue, a
// monitor pops and compares one entry after each clock edge or async-reset sample event.
module tb_door_access_arbiter;

  localparam logic [1:0] GL = 2'b10;
  localparam logic [1:0] GR = 2'b01;
  localparam logic [1:0] NO = 2'b00;

  logic clk;
  logic rst;
  door_access_arbiter_if dif ();

  door_access_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  string      nm_q[$];
  int         errors;
  int         checks;
  event       sample_ev;

  // Expected snapshot: {state, gnt_left, gnt_right, en_left, en_right, alarm, fail_cnt}.
  function automatic logic [9:0] ex(input logic [2:0] st, input logic [1:0] g,
                                    input logic [1:0] en, input logic al, input logic [1:0] fc);
    return {st, g, en, al, fc};
  endfunction

  // Monitor: compares the oldest expectation against the DUT outputs.
  initial begin
    logic [9:0] act;
    logic [9:0] e;
    string      nm;
    errors = 0;
    checks = 0;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = nm_q.pop_front();
        act = {dif.state, dif.gnt_left, dif.gnt_right, dif.en_left, dif.en_right,
               dif.alarm, dif.fail_cnt};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got st/gl,gr/el,er/al/fc=%b want %b", nm, act, e);
        end
      end
    end
  end

  // Push the expectation for the state after the next rising edge, then advance a cycle.
  task automatic tick_exp(input logic [9:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  // Assert reset between edges, check outputs cleared without a clock, then release.
  task automatic reset_pulse(input string nm);
    rst = 1'b0;
    exp_q.push_back(ex(3'd0, NO, NO, 1'b0, 2'd0));
    nm_q.push_back(nm);
    ->sample_ev;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst               = 1'b0;
    dif.req_left      = 1'b0;
    dif.req_right     = 1'b0;
    dif.confirm_left  = 1'b0;
    dif.confirm_right = 1'b0;
    dif.pass_left     = 4'd0;
    dif.pass_right    = 4'd0;
    @(negedge clk);
    reset_pulse("reset_state");

    // Left request, correct code two cycles later.
    dif.req_left = 1'b1;
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd0), "t1_grant");
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd0), "t1_grant_wait");
    dif.confirm_left = 1'b1;
    dif.pass_left    = 4'b1010;
    tick_exp(ex(3'd2, GL, NO, 1'b0, 2'd0), "t1_check");
    dif.confirm_left = 1'b0;
    dif.req_left     = 1'b0;
    for (int i = 0; i < 8; i++) tick_exp(ex(3'd3, GL, GL, 1'b0, 2'd0), "t1_open");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t1_idle_after_open");

    // Tie from reset: left first, right after one IDLE cycle.
    reset_pulse("t2_reset");
    dif.req_left  = 1'b1;
    dif.req_right = 1'b1;
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd0), "t2_tie_left");
    dif.confirm_left = 1'b1;
    dif.pass_left    = 4'b1010;
    tick_exp(ex(3'd2, GL, NO, 1'b0, 2'd0), "t2_check_left");
    dif.confirm_left = 1'b0;
    dif.req_left     = 1'b0;
    for (int i = 0; i < 8; i++) tick_exp(ex(3'd3, GL, GL, 1'b0, 2'd0), "t2_open_left");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t2_gap_idle");
    tick_exp(ex(3'd1, GR, NO, 1'b0, 2'd0), "t2_right_grant");
    dif.confirm_right = 1'b1;
    dif.pass_right    = 4'b1010;
    tick_exp(ex(3'd2, GR, NO, 1'b0, 2'd0), "t2_check_right");
    dif.confirm_right = 1'b0;
    dif.req_right     = 1'b0;
    for (int i = 0; i < 8; i++) tick_exp(ex(3'd3, GR, GR, 1'b0, 2'd0), "t2_open_right");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t2_idle");

    // Three wrong right-side codes -> lockout; left request held through LOCK.
    dif.req_right = 1'b1;
    tick_exp(ex(3'd1, GR, NO, 1'b0, 2'd0), "t3_grant1");
    dif.confirm_right = 1'b1;
    dif.pass_right    = 4'b1011;
    tick_exp(ex(3'd2, GR, NO, 1'b0, 2'd0), "t3_check1");
    dif.confirm_right = 1'b0;
    tick_exp(ex(3'd4, GR, NO, 1'b0, 2'd1), "t3_fail1");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd1), "t3_idle1");
    tick_exp(ex(3'd1, GR, NO, 1'b0, 2'd1), "t3_grant2");
    dif.confirm_right = 1'b1;
    dif.pass_right    = 4'b1100;
    tick_exp(ex(3'd2, GR, NO, 1'b0, 2'd1), "t3_check2");
    dif.confirm_right = 1'b0;
    tick_exp(ex(3'd4, GR, NO, 1'b0, 2'd2), "t3_fail2");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd2), "t3_idle2");
    tick_exp(ex(3'd1, GR, NO, 1'b0, 2'd2), "t3_grant3");
    dif.confirm_right = 1'b1;
    dif.pass_right    = 4'b0000;
    tick_exp(ex(3'd2, GR, NO, 1'b0, 2'd2), "t3_check3");
    dif.confirm_right = 1'b0;
    dif.req_right     = 1'b0;
    dif.req_left      = 1'b1;
    tick_exp(ex(3'd5, NO, NO, 1'b1, 2'd3), "t3_lock");
    for (int i = 1; i < 16; i++) begin
      dif.confirm_left = (i == 3);
      dif.pass_left    = 4'b1010;
      tick_exp(ex(3'd5, NO, NO, 1'b1, 2'd3), "t3_lock_hold");
    end
    dif.confirm_left = 1'b0;
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t3_lock_exit");
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd0), "t3_held_req_served");

    // Wrong code then correct code clears the fail count.
    dif.confirm_left = 1'b1;
    dif.pass_left    = 4'b0110;
    tick_exp(ex(3'd2, GL, NO, 1'b0, 2'd0), "t4_check_bad");
    dif.confirm_left = 1'b0;
    tick_exp(ex(3'd4, GL, NO, 1'b0, 2'd1), "t4_fail");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd1), "t4_idle");
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd1), "t4_regrant");
    dif.confirm_left = 1'b1;
    dif.pass_left    = 4'b1010;
    tick_exp(ex(3'd2, GL, NO, 1'b0, 2'd1), "t4_check_good");
    dif.confirm_left = 1'b0;
    dif.req_left     = 1'b0;
    for (int i = 0; i < 8; i++) tick_exp(ex(3'd3, GL, GL, 1'b0, 2'd0), "t4_open");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t4_idle_after_open");

    // Right grant times out; left confirm with the right code is ignored.
    dif.req_right    = 1'b1;
    dif.confirm_left = 1'b1;
    dif.pass_left    = 4'b1010;
    for (int i = 0; i < 12; i++) tick_exp(ex(3'd1, GR, NO, 1'b0, 2'd0), "t5_grant_wait");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t5_timeout");
    dif.req_right    = 1'b0;
    dif.confirm_left = 1'b0;
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t5_idle");

    // Reset mid-OPEN, then a normal service.
    dif.req_left = 1'b1;
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd0), "t6_grant");
    dif.confirm_left = 1'b1;
    tick_exp(ex(3'd2, GL, NO, 1'b0, 2'd0), "t6_check");
    dif.confirm_left = 1'b0;
    dif.req_left     = 1'b0;
    for (int i = 0; i < 4; i++) tick_exp(ex(3'd3, GL, GL, 1'b0, 2'd0), "t6_open_part");
    reset_pulse("t6_async_reset_mid_open");
    dif.req_left = 1'b1;
    tick_exp(ex(3'd1, GL, NO, 1'b0, 2'd0), "t6_grant_after_reset");
    dif.confirm_left = 1'b1;
    tick_exp(ex(3'd2, GL, NO, 1'b0, 2'd0), "t6_check_after_reset");
    dif.confirm_left = 1'b0;
    dif.req_left     = 1'b0;
    for (int i = 0; i < 8; i++) tick_exp(ex(3'd3, GL, GL, 1'b0, 2'd0), "t6_open_full");
    tick_exp(ex(3'd0, NO, NO, 1'b0, 2'd0), "t6_idle");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
